// File: rtl/img_downsample_seq.sv
`timescale 1ns/1ps
// img_downsample_seq: 2x2 box-filter downsampler between the source image RAM (port A reads) and the output image RAM.
// Latency: 4 x (1 ISSUE + N_wait) + 1 WRITE cycles per output pixel (9 with a zero-wait RAM); done the cycle after the last out_we.
// Backpressure: each read is held in WAIT until d_ready_re; with DS_TIMEOUT_EN a 256-cycle WAIT watchdog aborts the pass with err.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start / busy / done   : pass launch (sampled in IDLE), pass in progress, one-cycle completion pulse
//   mem_addr, mem_we      : source read address (registered), write enable (always 0)
//   mem_q, d_ready_re     : source read data and its ready strobe (honoured only in WAIT)
//   out_addr, out_data,
//   out_we                : output RAM write port, one strobe per averaged pixel
//   err                   : sticky read-timeout flag
//
// Build option: define DS_TIMEOUT_EN to include the WAIT watchdog and the err flag; otherwise err is constant 0.
module img_downsample_seq #(
    parameter int          IMG_W      = 512,
    parameter int          IMG_H      = 512,
    parameter int          ADDR_W     = 19,
    parameter int          OUT_ADDR_W = 17,
    parameter int unsigned SRC_BASE   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_we,
    input  logic [7:0]            mem_q,
    input  logic                  d_ready_re,
    output logic [OUT_ADDR_W-1:0] out_addr,
    output logic [7:0]            out_data,
    output logic                  out_we,
    output logic                  err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_FIN
    } state_t;

    localparam int OUT_W = IMG_W / 2;
    localparam int OUT_H = IMG_H / 2;

    state_t      state;
    logic [15:0] ox;
    logic [15:0] oy;
    logic [1:0]  k;
    logic [9:0]  acc;

    // Address arithmetic is done at full port width; the casts make the
    // truncation/extension explicit.
    logic [ADDR_W-1:0]     src_row;
    logic [ADDR_W-1:0]     src_col;
    logic [ADDR_W-1:0]     src_addr;
    logic [OUT_ADDR_W-1:0] dst_addr;
    logic [9:0]            acc_sum;
    logic [9:0]            acc_rnd;
    logic                  ox_last;
    logic                  oy_last;

    always_comb begin
        // Tap k: bit 1 selects the bottom row, bit 0 the right column.
        src_row  = ADDR_W'({oy, 1'b0}) + ADDR_W'(k[1]);
        src_col  = ADDR_W'({ox, 1'b0}) + ADDR_W'(k[0]);
        src_addr = ADDR_W'(SRC_BASE) + src_row * ADDR_W'(IMG_W) + src_col;
        dst_addr = OUT_ADDR_W'(oy) * OUT_ADDR_W'(OUT_W) + OUT_ADDR_W'(ox);
        acc_sum  = acc + 10'(mem_q);
        // Four bytes sum to at most 1020, so +2 and >>2 always fits 8 bits.
        acc_rnd  = (acc_sum + 10'd2) >> 2;
        ox_last  = (ox == 16'(OUT_W - 1));
        oy_last  = (oy == 16'(OUT_H - 1));
    end

`ifdef DS_TIMEOUT_EN
    logic [7:0] wd_cnt;
    logic       err_r;
    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign mem_we = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            out_we   <= 1'b0;
            mem_addr <= '0;
            out_addr <= '0;
            out_data <= '0;
            ox       <= '0;
            oy       <= '0;
            k        <= '0;
            acc      <= '0;
`ifdef DS_TIMEOUT_EN
            wd_cnt   <= '0;
            err_r    <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle; only the transitions below raise them.
            done   <= 1'b0;
            out_we <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        ox    <= '0;
                        oy    <= '0;
                        k     <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
`ifdef DS_TIMEOUT_EN
                        err_r <= 1'b0;
`endif
                        state <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    // d_ready_re is deliberately ignored here: a strobe left
                    // over from the previous address must not be counted.
                    mem_addr <= src_addr;
`ifdef DS_TIMEOUT_EN
                    wd_cnt   <= '0;
`endif
                    state    <= S_WAIT;
                end

                S_WAIT: begin
                    if (d_ready_re) begin
                        acc <= acc_sum;
                        if (k != 2'd3) begin
                            k     <= k + 2'd1;
                            state <= S_ISSUE;
                        end else begin
                            // Output registers are loaded here so that out_we,
                            // out_addr and out_data are all valid in WRITE.
                            out_data <= acc_rnd[7:0];
                            out_addr <= dst_addr;
                            out_we   <= 1'b1;
                            state    <= S_WRITE;
                        end
                    end
`ifdef DS_TIMEOUT_EN
                    else if (wd_cnt == 8'hFF) begin
                        // 256th WAIT cycle without a response: abandon the pass.
                        err_r <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_FIN;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
`endif
                end

                S_WRITE: begin
                    acc <= '0;
                    k   <= '0;
                    if (ox_last && oy_last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_FIN;
                    end else begin
                        if (ox_last) begin
                            ox <= '0;
                            oy <= oy + 16'd1;
                        end else begin
                            ox <= ox + 16'd1;
                        end
                        state <= S_ISSUE;
                    end
                end

                S_FIN: begin
                    // start is not sampled here, so a start coinciding with
                    // done is dropped.
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/img_downsample_seq.md
# img_downsample_seq

2x2 box-filter downsampling sequencer that sits directly downstream of the input image RAM. It walks the stored source image through the RAM's port A read handshake, one address per request, and waits for `d_ready_re` on each request. For each 2x2 block it averages the four pixels and writes one rounded byte per output pixel to the output image RAM. A `start` pulse launches one full pass; `done` reports completion.

## Interface
Parameters:
- `IMG_W`, 512: source width in pixels; even, ≥2.
- `IMG_H`, 512: source height in pixels; even, ≥2.
- `ADDR_W`, 19: source address width.
- `OUT_ADDR_W`, 17: output address width.
- `SRC_BASE`, 0: source address of pixel (0,0).

Ports:
- `clk`, in, 1: single clock; all logic on rising edge.
- `rst_n`, in, 1: reset; asynchronous, active-low.
- `start`, in, 1: launch a pass; sampled in IDLE only.
- `busy`, out, 1: high from the cycle after `start` is accepted until `done`.
- `done`, out, 1: one-cycle pulse at end of pass.
- `mem_addr`, out, `ADDR_W`: source read address, registered.
- `mem_we`, out, 1: tied 0; this block never writes the source RAM.
- `mem_q`, in, 8: source read data.
- `d_ready_re`, in, 1: source RAM read-ready strobe.
- `out_addr`, out, `OUT_ADDR_W`: output pixel address.
- `out_data`, out, 8: averaged pixel.
- `out_we`, out, 1: one-cycle write strobe to the output RAM.
- `err`, out, 1: sticky read-timeout flag; present only with `DS_TIMEOUT_EN`, otherwise tied 0.

## Operation
- **States:** IDLE, ISSUE, WAIT, WRITE, FIN.
- **IDLE:**
  - On `start`=1, clear `ox`, `oy`, tap index `k`, accumulator `acc` (10 bit) and `err`.
  - Go to ISSUE.
- **ISSUE:**
  - Register `mem_addr` = SRC_BASE + (2·oy + k[1])·IMG_W + 2·ox + k[0].
  - Taps are ordered k=0..3: top-left, top-right, bottom-left, bottom-right.
  - Go to WAIT.
- **WAIT:**
  - Hold `mem_addr` stable.
  - On `d_ready_re`=1: `acc` += `mem_q`.
    - If k<3, increment k and go to ISSUE.
    - Otherwise go to WRITE.
- **WRITE:**
  - `out_data` = (acc + 2) >> 2, rounded half-up, 8 bit, cannot overflow.
  - `out_addr` = oy·(IMG_W/2) + ox.
  - `out_we`=1 for exactly this cycle.
  - Clear `acc` and `k`, then advance `ox`. When `ox` wraps at IMG_W/2−1, clear it and increment `oy`.
  - After the last output pixel (ox=IMG_W/2−1, oy=IMG_H/2−1), go to FIN; otherwise go to ISSUE.
- **FIN:** `done`=1 for one cycle, `busy` drops, go to IDLE.
- Arithmetic: every address is computed at full width before truncation to the port width. Products use `ADDR_W` and `OUT_ADDR_W` bits respectively.

## Timing
- **Reset values:** state IDLE; `busy`, `done`, `out_we`, `mem_we`, `err` = 0; `mem_addr`, `out_addr`, `out_data` = 0.
- **Handshake:**
  - `d_ready_re` is ignored in ISSUE and IDLE. A stale strobe from the previous address must not be counted.
  - `d_ready_re` is accepted only in WAIT. `mem_q` is sampled in that same cycle.
- **Per output pixel:** 4 reads × (1 ISSUE + N_wait) + 1 WRITE cycles. With the RAM answering on the first WAIT cycle, this is 9 cycles.
- **Pass latency:** `done` is asserted the cycle after the final `out_we`.
- **Simultaneous events:**
  - `start` while `busy` is ignored.
  - `start` coinciding with `done` is ignored; it is accepted again from the next IDLE cycle.
- **Reset mid-pass:** immediate return to IDLE with all outputs cleared. No partial write completes. Output RAM contents are left as-is.

## Configuration
- `DS_TIMEOUT_EN` defined:
  - An 8-bit watchdog counts WAIT cycles and clears on every ISSUE.
  - If it reaches 255 without `d_ready_re`, set `err`=1 (sticky until the next accepted `start`) and go to FIN.
  - `done` still pulses; no further `out_we` is issued.
- `DS_TIMEOUT_EN` undefined:
  - No counter; WAIT waits indefinitely.
  - `err` is a constant 0.

## Test plan
- **Single block:** IMG_W=IMG_H=2, source {10,20,30,41}, RAM ready on the first WAIT cycle.
  - Expect exactly one `out_we` with out_addr=0, out_data=25 (101+2=103, >>2 → 25).
  - Expect `done` 10 cycles after `start`.
- **Addressing:** IMG_W=IMG_H=4, source value = address.
  - Expect outputs {3,5,11,13} at out_addr 0..3.
  - Expect mem_addr sequence 0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15.
- **Delayed ready:** ready asserted 7 cycles into each WAIT, with a spurious `d_ready_re` pulse during each ISSUE.
  - Expect the same outputs as the addressing scenario.
  - Expect no extra accumulation.
- **Rounding and saturation:**
  - Source {255,255,255,255} → 255.
  - Source {0,0,0,1} → 0.
  - Source {0,0,1,1} → 1.
- **Reset and start:**
  - `start` held high during the pass → only one pass runs.
  - `rst_n` low during the 3rd output pixel's WAIT → `busy`=0 and `out_we`=0 immediately; the 3rd pixel is never written.
- **Timeout:** with `DS_TIMEOUT_EN`, `d_ready_re` tied 0.
  - Expect `err`=1 and `done` after 256 WAIT cycles, with no `out_we`.
  - A following `start` with a working RAM clears `err`.
